csa_pipe_adder: RTL and testbench

- Parametrised, pipelined carry-select adder/subtractor for the booth_mul datapath and other wide arithmetic in digital_arith.
- Operand is split into fixed-width carry-select blocks; a register stage is inserted after every STAGE_BLOCKS blocks, with operand/result skew buffering.
- Adds subtract mode, signed-overflow flag and a valid/ready stream handshake, so partial-product accumulation can run at a higher clock rate.

---
 rtl/csa_pkg.sv | 24 ++
 rtl/csa_pipe_stage.sv | 31 +++
 rtl/csa_pipe_adder.sv | 134 +++++++++++++
 tb/tb_csa_pipe_adder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared types and derivation helpers for the pipelined carry-select adder
package csa_pkg;

  typedef enum logic {CSA_ADD = 1'b0, CSA_SUB = 1'b1} csa_op_e;

  localparam int CSA_MIN_LAT = 1;

  function automatic int csa_ceil_div(int a, int b);
    if (b < 1) return 1;
    return (a + b - 1) / b;
  endfunction

  function automatic int csa_nblk(int width, int block);
    if (block < 1) return 1;
    return width / block;
  endfunction

  function automatic int csa_lat(int width, int block, int stage_blocks);
    int l;
    l = csa_ceil_div(csa_nblk(width, block), stage_blocks);
    return (l < CSA_MIN_LAT) ? CSA_MIN_LAT : l;
  endfunction

endpackage

// File: rtl/csa_pipe_stage.sv
// rtl/csa_pipe_stage.sv - combinational chain of NB carry-select blocks
module csa_pipe_stage #(
  parameter int BLOCK = 4,
  parameter int NB    = 2
) (
  input  logic [NB*BLOCK-1:0] a,
  input  logic [NB*BLOCK-1:0] bx,
  input  logic                cin,
  output logic [NB*BLOCK-1:0] sum,
  output logic                cout
);

  logic [NB:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < NB; i++) begin : g_blk
    logic [BLOCK:0] s0;
    logic [BLOCK:0] s1;

    // Both carry hypotheses are formed up front; the ripple only drives the mux.
    assign s0 = {1'b0, a[i*BLOCK +: BLOCK]} + {1'b0, bx[i*BLOCK +: BLOCK]};
    assign s1 = {1'b0, a[i*BLOCK +: BLOCK]} + {1'b0, bx[i*BLOCK +: BLOCK]} + {{BLOCK{1'b0}}, 1'b1};

    assign sum[i*BLOCK +: BLOCK] = carry[i] ? s1[BLOCK-1:0] : s0[BLOCK-1:0];
    assign carry[i+1]            = carry[i] ? s1[BLOCK]     : s0[BLOCK];
  end

  assign cout = carry[NB];

endmodule

// File: rtl/csa_pipe_adder.sv
// rtl/csa_pipe_adder.sv - pipelined carry-select adder/subtractor with valid/ready stream handshake
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int BLOCK        = 4,
  parameter int STAGE_BLOCKS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Carry_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] S,
  output logic             Carry_o,
  output logic             Ovf_o
);

  localparam int NBLK = csa_nblk(WIDTH, BLOCK);
  localparam int LAT  = csa_lat(WIDTH, BLOCK, STAGE_BLOCKS);

  if (BLOCK < 1 || WIDTH < BLOCK || (WIDTH % BLOCK) != 0) begin : g_bad_width
    $error("csa_pipe_adder: WIDTH must be a non-zero multiple of BLOCK");
  end
  if (STAGE_BLOCKS < 1) begin : g_bad_stage
    $error("csa_pipe_adder: STAGE_BLOCKS must be at least 1");
  end

  csa_op_e          op;
  logic [WIDTH-1:0] bx_prep;
  logic             cin_prep;
  logic             en;

  assign op       = sub_i ? CSA_SUB : CSA_ADD;
  assign bx_prep  = (op == CSA_SUB) ? ~B : B;
  assign cin_prep = (op == CSA_SUB) ? 1'b1 : Carry_i;

  // One global advance: a stalled output freezes every stage, bubbles included.
  assign en      = ready_i | ~valid_o;
  assign ready_o = en;

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    localparam int LO  = k * STAGE_BLOCKS;
    localparam int HI  = ((k + 1) * STAGE_BLOCKS < NBLK) ? (k + 1) * STAGE_BLOCKS : NBLK;
    localparam int LOB = LO * BLOCK;
    localparam int HB  = HI * BLOCK;
    localparam int NBB = HB - LOB;

    logic [WIDTH-1:LOB] a_in;
    logic [WIDTH-1:LOB] bx_in;
    logic               c_in;
    logic               v_in;
    logic [NBB-1:0]     sum;
    logic               cout;
    logic [HB-1:0]      s_next;
    logic [HB-1:0]      s_q;
    logic               c_q;
    logic               v_q;

    if (k == 0) begin : g_head
      assign a_in   = A;
      assign bx_in  = bx_prep;
      assign c_in   = cin_prep;
      assign v_in   = valid_i;
      assign s_next = sum;
    end else begin : g_body
      assign a_in   = g_stage[k-1].g_fwd.a_q;
      assign bx_in  = g_stage[k-1].g_fwd.bx_q;
      assign c_in   = g_stage[k-1].c_q;
      assign v_in   = g_stage[k-1].v_q;
      assign s_next = {sum, g_stage[k-1].s_q};
    end

    csa_pipe_stage #(
      .BLOCK (BLOCK),
      .NB    (HI - LO)
    ) u_stage (
      .a    (a_in[LOB +: NBB]),
      .bx   (bx_in[LOB +: NBB]),
      .cin  (c_in),
      .sum  (sum),
      .cout (cout)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (en) begin
        s_q <= s_next;
        c_q <= cout;
        v_q <= v_in;
      end
    end

    if (k < LAT - 1) begin : g_fwd
      // Skew buffer: only operand bits not yet consumed travel onward.
      logic [WIDTH-1:HB] a_q;
      logic [WIDTH-1:HB] bx_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q  <= '0;
          bx_q <= '0;
        end else if (en) begin
          a_q  <= a_in[WIDTH-1:HB];
          bx_q <= bx_in[WIDTH-1:HB];
        end
      end
    end else begin : g_last
      logic ovf_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= (a_in[WIDTH-1] ~^ bx_in[WIDTH-1]) & (sum[NBB-1] ^ a_in[WIDTH-1]);
        end
      end
    end
  end

  assign valid_o = g_stage[LAT-1].v_q;
  assign S       = g_stage[LAT-1].s_q;
  assign Carry_o = g_stage[LAT-1].c_q;
  assign Ovf_o   = g_stage[LAT-1].g_last.ovf_q;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// tb/tb_csa_pipe_adder.sv - scoreboard bench for csa_pipe_adder over three parameter sets
module tb_csa_pipe_adder;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic clk     = 1'b0;
  logic rst     = 1'b0;
  bit   go      = 1'b0;

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic logic [33:0] model(int w, logic [31:0] a, logic [31:0] b, logic c, logic sub);
    longint ua, ub, full, mask, half, sa, sb, r;
    logic   co, ov;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    if (sub) begin
      full = ua - ub;
      co   = (ua >= ub);
    end else begin
      full = ua + ub + longint'(c);
      co   = (full > mask);
    end
    sa = (ua >= half) ? ua - 2 * half : ua;
    sb = (ub >= half) ? ub - 2 * half : ub;
    r  = sub ? sa - sb : sa + sb + longint'(c);
    ov = (r >= half) || (r < -half);
    return {ov, co, 32'(full & mask)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- DUT 0: WIDTH=16 BLOCK=4 STAGE_BLOCKS=2 (LAT=2) ----------------
  logic        d0_valid_i = 1'b0, d0_ready_i = 1'b0, d0_c = 1'b0, d0_sub = 1'b0;
  logic [15:0] d0_a = '0, d0_b = '0;
  logic        d0_ready_o, d0_valid_o, d0_co, d0_ov;
  logic [15:0] d0_s;
  logic [33:0] q0[$];
  int          d0_pops = 0;

  csa_pipe_adder #(.WIDTH(16), .BLOCK(4), .STAGE_BLOCKS(2)) dut0 (
    .clk(clk), .rst(rst), .valid_i(d0_valid_i), .ready_o(d0_ready_o),
    .A(d0_a), .B(d0_b), .Carry_i(d0_c), .sub_i(d0_sub),
    .valid_o(d0_valid_o), .ready_i(d0_ready_i), .S(d0_s), .Carry_o(d0_co), .Ovf_o(d0_ov)
  );

  always @(negedge clk) begin
    if (!rst && d0_valid_o && d0_ready_i) begin
      d0_pops++;
      if (q0.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL d0 output with empty scoreboard: got %0h", d0_s);
      end else begin
        check("d0 result", 64'({d0_ov, d0_co, 16'h0, d0_s}), 64'(q0.pop_front()));
      end
    end
  end

  task automatic d0_beat(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic sub, input logic [33:0] exp);
    int n;
    @(posedge clk); #1;
    d0_a = a; d0_b = b; d0_c = c; d0_sub = sub;
    d0_valid_i = 1'b1;
    d0_ready_i = 1'b1;
    @(negedge clk);
    check("d0 ready_o idle", 64'(d0_ready_o), 64'd1);
    q0.push_back(exp);
    @(posedge clk); #1;
    d0_valid_i = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (d0_valid_o) break;
      n++;
    end
    check("d0 latency", 64'(n), 64'd1);
    repeat (2) @(posedge clk);
  endtask

  // ---------------- Sweep DUTs: LAT=1 and LAT=3 ----------------
  localparam int GW[2] = '{20, 32};
  localparam int GS[2] = '{5, 3};

  for (genvar g = 0; g < 2; g++) begin : u_sw
    localparam int W = GW[g];
    logic         valid_i = 1'b0, ready_i = 1'b0, c = 1'b0, sub = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         ready_o, valid_o, co, ov;
    logic [W-1:0] s;
    logic [33:0]  q[$];
    bit           done_r = 1'b0;

    csa_pipe_adder #(.WIDTH(W), .BLOCK(4), .STAGE_BLOCKS(GS[g])) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
      .A(a), .B(b), .Carry_i(c), .sub_i(sub),
      .valid_o(valid_o), .ready_i(ready_i), .S(s), .Carry_o(co), .Ovf_o(ov)
    );

    always @(negedge clk) begin
      if (!rst && valid_o && ready_i) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sweep W%0d output with empty scoreboard: got %0h", W, s);
        end else begin
          check($sformatf("sweep W%0d result", W), 64'({ov, co, 32'(s)}), 64'(q.pop_front()));
        end
      end
    end

    initial begin
      int  acc;
      bit  took;
      acc  = 0;
      took = 1'b0;
      wait (go);
      for (int cyc = 0; cyc < 40000 && acc < 10000; cyc++) begin
        @(posedge clk); #1;
        if (!valid_i || took) begin
          valid_i = ($urandom_range(3) != 0);
          a       = W'($urandom);
          b       = W'($urandom);
          c       = 1'($urandom);
          sub     = 1'($urandom);
        end
        ready_i = ($urandom_range(3) != 0);
        @(negedge clk);
        took = valid_i && ready_o;
        if (took) begin
          q.push_back(model(W, 32'(a), 32'(b), c, sub));
          acc++;
        end
      end
      @(posedge clk); #1;
      valid_i = 1'b0;
      ready_i = 1'b1;
      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
      check($sformatf("sweep W%0d beats accepted", W), 64'(acc), 64'd10000);
      check($sformatf("sweep W%0d drained", W), 64'(q.size()), 64'd0);
      done_r = 1'b1;
    end
  end

  // ---------------- Main sequence ----------------
  initial begin
    int          idx, stall, pops0;
    bit          first_seen, took;
    logic [15:0] held;
    logic [15:0] sa[8], sb[8];
    logic        sc[8], ss[8];

    // Reset asserted between edges clears outputs without a clock.
    d0_a = 16'($urandom); d0_b = 16'($urandom); d0_valid_i = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("reset valid_o", 64'(d0_valid_o), 64'd0);
    check("reset S", 64'(d0_s), 64'd0);
    check("reset Carry_o", 64'(d0_co), 64'd0);
    check("reset Ovf_o", 64'(d0_ov), 64'd0);
    d0_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    d0_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000});
    d0_beat(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF});
    d0_beat(16'h0000, 16'h0001, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF});
    d0_beat(16'h7FFF, 16'h0000, 1'b1, 1'b0, {1'b1, 1'b0, 32'h8000});

    // Eight back-to-back beats with a three-cycle downstream stall after the first result.
    for (int i = 0; i < 8; i++) begin
      sa[i] = 16'($urandom); sb[i] = 16'($urandom);
      sc[i] = 1'($urandom);  ss[i] = 1'($urandom);
    end
    idx = 0; stall = 0; first_seen = 1'b0; held = '0; pops0 = d0_pops;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk); #1;
      d0_ready_i = (stall == 0);
      d0_valid_i = (idx < 8);
      if (idx < 8) begin
        d0_a = sa[idx]; d0_b = sb[idx]; d0_c = sc[idx]; d0_sub = ss[idx];
      end
      @(negedge clk);
      if (stall > 0) begin
        check("stall ready_o", 64'(d0_ready_o), 64'd0);
        check("stall valid_o", 64'(d0_valid_o), 64'd1);
        if (stall == 3) held = d0_s;
        else check("stall S hold", 64'(d0_s), 64'(held));
        stall--;
      end else if (!first_seen && d0_valid_o) begin
        first_seen = 1'b1;
        stall      = 3;
      end
      if (d0_valid_i && d0_ready_o) begin
        q0.push_back(model(16, 32'(sa[idx]), 32'(sb[idx]), sc[idx], ss[idx]));
        idx++;
      end
      if (idx == 8 && q0.size() == 0 && stall == 0) break;
    end
    @(posedge clk); #1;
    d0_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    check("stream delivered", 64'(d0_pops - pops0), 64'd8);

    // Two beats in flight are discarded by a reset pulse.
    @(posedge clk); #1;
    d0_ready_i = 1'b0; d0_valid_i = 1'b1; d0_sub = 1'b0; d0_c = 1'b0;
    d0_a = 16'h0F0F; d0_b = 16'h0101;
    @(posedge clk); #1;
    d0_a = 16'h5555; d0_b = 16'h2222;
    @(posedge clk); #1;
    d0_valid_i = 1'b0;
    #1 rst = 1'b1;
    q0.delete();
    #1;
    check("flush valid_o", 64'(d0_valid_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    d0_beat(16'h1234, 16'h1111, 1'b0, 1'b0, {1'b0, 1'b0, 32'h2345});

    // Random traffic on all three configurations concurrently.
    go = 1'b1;
    took = 1'b0;
    idx  = 0;
    for (int cyc = 0; cyc < 40000 && idx < 6000; cyc++) begin
      @(posedge clk); #1;
      if (!d0_valid_i || took) begin
        d0_valid_i = ($urandom_range(3) != 0);
        d0_a = 16'($urandom); d0_b = 16'($urandom);
        d0_c = 1'($urandom);  d0_sub = 1'($urandom);
      end
      d0_ready_i = ($urandom_range(3) != 0);
      @(negedge clk);
      took = d0_valid_i && d0_ready_o;
      if (took) begin
        q0.push_back(model(16, 32'(d0_a), 32'(d0_b), d0_c, d0_sub));
        idx++;
      end
    end
    @(posedge clk); #1;
    d0_valid_i = 1'b0;
    d0_ready_i = 1'b1;
    for (int i = 0; i < 50000 && !(u_sw[0].done_r && u_sw[1].done_r); i++) @(posedge clk);
    check("sweep finished", 64'({u_sw[0].done_r, u_sw[1].done_r}), 64'd3);
    check("d0 random drained", 64'(q0.size()), 64'd0);

    // Reset in the middle of a stalled, full pipeline.
    @(posedge clk); #1;
    d0_ready_i = 1'b0; d0_valid_i = 1'b1;
    d0_a = 16'($urandom) | 16'h0001; d0_b = 16'($urandom);
    repeat (3) @(posedge clk);
    check("pre-reset valid_o", 64'(d0_valid_o), 64'd1);
    #2 rst = 1'b1;
    q0.delete();
    #1;
    check("mid reset valid_o", 64'(d0_valid_o), 64'd0);
    check("mid reset S", 64'(d0_s), 64'd0);
    check("mid reset Carry_o", 64'(d0_co), 64'd0);
    check("mid reset Ovf_o", 64'(d0_ov), 64'd0);
    d0_valid_i = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
